// File: rtl/chan_err_if.sv
// Word stream bundle for the channel error injector.
// The master drives input words; the slave returns delayed, possibly corrupted words.
interface chan_err_if #(
    parameter int WORD_W = 2
) ();
    logic              i_vld;
    logic [WORD_W-1:0] i_word;
    logic              o_vld;
    logic [WORD_W-1:0] o_word;
    logic              o_err_flag;

    modport master (
        output i_vld,
        output i_word,
        input  o_vld,
        input  o_word,
        input  o_err_flag
    );

    modport slave (
        input  i_vld,
        input  i_word,
        output o_vld,
        output o_word,
        output o_err_flag
    );
endinterface

// File: rtl/chan_err_injector.sv
// Channel error injector: single/burst/periodic word corruption, one cycle latency.
// Optional random mode (LFSR threshold) is built when CHAN_ERR_INJ_RANDOM_EN is defined.
module chan_err_injector #(
    parameter int WORD_W  = 2,
    parameter int RATE_W  = 11,
    parameter int BURST_W = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_enable,
    input  logic [1:0]         i_mode,
    input  logic [RATE_W-1:0]  i_first_err,
    input  logic [RATE_W-1:0]  i_err_rate,
    input  logic [BURST_W-1:0] i_burst_len,
    input  logic [WORD_W-1:0]  i_bit_mask,
    input  logic               i_rot_en,
    chan_err_if.slave          bus,
    output logic [CNT_W-1:0]   o_err_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FIRST,
        BURST,
        GAP
    } state_t;

    state_t             state_q, state_d, st_e;
    logic [1:0]         mode_q, mode_d, mode_e;
    logic [RATE_W-1:0]  first_q, first_d, first_e;
    logic [RATE_W-1:0]  rate_q, rate_d, rate_e;
    logic [BURST_W-1:0] blen_q, blen_d, blen_e;
    logic [WORD_W-1:0]  mask_q, mask_d, mask_e;
    logic               rot_q, rot_d, rot_e;
    logic [RATE_W-1:0]  cnt_q, cnt_d, cnt_e;
    logic [RATE_W-1:0]  pcnt_q, pcnt_d, pcnt_e;
    logic [BURST_W-1:0] bleft_q, bleft_d, bleft_e;
    logic [BURST_W-1:0] eff_len;

    logic               o_vld_q, o_vld_d;
    logic [WORD_W-1:0]  o_word_q, o_word_d;
    logic               o_flag_q, o_flag_d;
    logic [CNT_W-1:0]   o_cnt_q, o_cnt_d;

    logic               idle;
    logic               restart;
    logic               start;
    logic               corrupt;
    logic               is_rand;

`ifdef CHAN_ERR_INJ_RANDOM_EN
    logic [22:0]        lfsr_q, lfsr_d;
`endif

    function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] m);
        logic [WORD_W-1:0] r;
        r = (m << 1) | (m >> (WORD_W - 1));
        return r;
    endfunction

    // In IDLE the live inputs act as the configuration so the enabling word is evaluated.
    always_comb begin
        idle    = (state_q == IDLE);
        st_e    = idle ? WAIT_FIRST : state_q;
        mode_e  = idle ? i_mode : mode_q;
        first_e = idle ? i_first_err : first_q;
        rate_e  = idle ? i_err_rate : rate_q;
        blen_e  = idle ? i_burst_len : blen_q;
        mask_e  = idle ? i_bit_mask : mask_q;
        rot_e   = idle ? i_rot_en : rot_q;
        cnt_e   = idle ? '0 : cnt_q;
        pcnt_e  = idle ? '0 : pcnt_q;
        bleft_e = idle ? '0 : bleft_q;
    end

    always_comb begin
        eff_len = BURST_W'(1);
        if (mode_e == 2'd1 && blen_e != '0) begin
            eff_len = blen_e;
        end
        restart = (rate_e != '0) && (pcnt_e == rate_e - RATE_W'(1));
    end

`ifdef CHAN_ERR_INJ_RANDOM_EN
    always_comb begin
        is_rand = (mode_e == 2'd2);
        lfsr_d  = lfsr_q;
        if (i_enable && bus.i_vld) begin
            lfsr_d = {lfsr_q[21:0], lfsr_q[22] ^ lfsr_q[17]};
        end
    end
`else
    always_comb begin
        is_rand = 1'b0;
    end
`endif

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        first_d = first_q;
        rate_d  = rate_q;
        blen_d  = blen_q;
        mask_d  = mask_q;
        rot_d   = rot_q;
        cnt_d   = cnt_q;
        pcnt_d  = pcnt_q;
        bleft_d = bleft_q;
        start   = 1'b0;
        corrupt = 1'b0;

        if (!i_enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            pcnt_d  = '0;
            bleft_d = '0;
        end else begin
            state_d = st_e;
            mode_d  = mode_e;
            first_d = first_e;
            rate_d  = rate_e;
            blen_d  = blen_e;
            mask_d  = mask_e;
            rot_d   = rot_e;
            cnt_d   = cnt_e;
            pcnt_d  = pcnt_e;
            bleft_d = bleft_e;

            if (bus.i_vld) begin
                if (is_rand) begin
`ifdef CHAN_ERR_INJ_RANDOM_EN
                    corrupt = (lfsr_q[RATE_W-1:0] < rate_e);
`endif
                end else begin
                    unique case (st_e)
                        WAIT_FIRST: begin
                            if (cnt_e == first_e) begin
                                start = 1'b1;
                            end else begin
                                cnt_d = cnt_e + RATE_W'(1);
                            end
                        end
                        BURST: begin
                            if (restart) begin
                                start = 1'b1;
                            end else begin
                                corrupt = 1'b1;
                                bleft_d = bleft_e - BURST_W'(1);
                                if (bleft_e == BURST_W'(1)) begin
                                    state_d = GAP;
                                end
                                if (pcnt_e != '1) begin
                                    pcnt_d = pcnt_e + RATE_W'(1);
                                end
                            end
                        end
                        GAP: begin
                            if (restart) begin
                                start = 1'b1;
                            end else if (pcnt_e != '1) begin
                                pcnt_d = pcnt_e + RATE_W'(1);
                            end
                        end
                        default: begin
                        end
                    endcase
                end

                // A burst start overrides whatever burst was still running.
                if (start) begin
                    corrupt = 1'b1;
                    pcnt_d  = '0;
                    bleft_d = eff_len - BURST_W'(1);
                    state_d = (eff_len > BURST_W'(1)) ? BURST : GAP;
                end

                if (corrupt && rot_e) begin
                    mask_d = rotl(mask_e);
                end
            end
        end
    end

    always_comb begin
        o_vld_d  = bus.i_vld;
        o_word_d = bus.i_word ^ (corrupt ? mask_e : '0);
        o_flag_d = corrupt;
        o_cnt_d  = o_cnt_q;
        if (corrupt && o_cnt_q != '1) begin
            o_cnt_d = o_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            mode_q   <= '0;
            first_q  <= '0;
            rate_q   <= '0;
            blen_q   <= '0;
            mask_q   <= '0;
            rot_q    <= 1'b0;
            cnt_q    <= '0;
            pcnt_q   <= '0;
            bleft_q  <= '0;
            o_vld_q  <= 1'b0;
            o_word_q <= '0;
            o_flag_q <= 1'b0;
            o_cnt_q  <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            first_q  <= first_d;
            rate_q   <= rate_d;
            blen_q   <= blen_d;
            mask_q   <= mask_d;
            rot_q    <= rot_d;
            cnt_q    <= cnt_d;
            pcnt_q   <= pcnt_d;
            bleft_q  <= bleft_d;
            o_vld_q  <= o_vld_d;
            o_word_q <= o_word_d;
            o_flag_q <= o_flag_d;
            o_cnt_q  <= o_cnt_d;
        end
    end

`ifdef CHAN_ERR_INJ_RANDOM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= 23'h7FFFFF;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`endif

    assign bus.o_vld      = o_vld_q;
    assign bus.o_word     = o_word_q;
    assign bus.o_err_flag = o_flag_q;
    assign o_err_cnt      = o_cnt_q;

endmodule

// File: doc/chan_err_injector.md
# chan_err_injector

- Parametrised channel error injector that sits between the convolutional encoder and the Fano decoder in the link bench.
- Generalises the fixed 2-bit periodic error generator: any word width, single or burst errors, a selectable bit mask that can rotate, and a running count of corrupted words.
- Registered pass-through with one cycle of latency; the valid pattern is preserved exactly.

## Interface
- WORD_W, 2, width of the code word (bits per valid).
- RATE_W, 11, width of the first-error and error-period fields.
- BURST_W, 4, width of the burst-length field.
- CNT_W, 32, width of the corrupted-word counter.
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- i_enable  in  1  injection enable; 0 = transparent.
- i_mode  in  2  0 = single, 1 = burst, 2 = random (see Configuration), 3 = same as 0.
- i_first_err  in  RATE_W  0-based index of the first valid word corrupted after enable.
- i_err_rate  in  RATE_W  period in valid words between burst starts (0 = first burst only); in random mode, this is the threshold.
- i_burst_len  in  BURST_W  words per burst in mode 1 (0 treated as 1).
- i_bit_mask  in  WORD_W  XOR mask applied to corrupted words.
- i_rot_en  in  1  rotate the mask left by 1 after each corrupted word.
- i_vld  in  1  input word valid.
- i_word  in  WORD_W  input code word.
- o_vld  out  1  output valid, i_vld delayed by 1 cycle.
- o_word  out  WORD_W  output word: i_word, or i_word ^ mask when corrupted.
- o_err_flag  out  1  high with o_vld when o_word is corrupted.
- o_err_cnt  out  CNT_W  corrupted words since reset; saturating.

## Operation
- Configuration is latched in IDLE on the cycle i_enable is first seen high. Changes while enabled are ignored until i_enable drops.
- Latched fields: i_mode, i_first_err, i_err_rate, i_burst_len, i_bit_mask, i_rot_en.
- States:
  - IDLE: pass-through, no corruption. Goes to WAIT_FIRST when i_enable=1. The word index cnt and the period counter pcnt are cleared.
  - WAIT_FIRST: on each i_vld, if cnt==first_err the word is a burst start; otherwise cnt++.
  - BURST: corrupt each valid word; burst_left-- per word; go to GAP when burst_left reaches 0.
  - GAP: no corruption.
- Burst start: corrupt the word, set pcnt=0 and burst_left = eff_len-1, then go to BURST if burst_left>0, else GAP.
  - eff_len = 1 in mode 0.
  - eff_len = max(i_burst_len,1) in mode 1.
- Periodic restart in BURST/GAP: on i_vld with err_rate≠0 and pcnt==err_rate-1, start a new burst. Otherwise pcnt++ (saturating).
- A new burst start truncates any burst still in progress.
- err_rate=0: after the first burst, stay in GAP until disabled.
- err_rate=1 in mode 0: every valid word from first_err onward is corrupted.
- i_enable=0 in any state returns to IDLE on the next cycle. The word in that same cycle is not corrupted.
- Mask handling:
  - With rotation on, the working mask rotates left by 1 bit (MSB to LSB) after each corrupted word.
  - An all-zero mask still sets o_err_flag and counts, but o_word equals i_word.
- o_err_cnt increments on every corrupted word and saturates at 2^CNT_W-1. It is not cleared by i_enable, only by reset.

## Timing
- Latency is 1 cycle:
  - o_vld(t+1) = i_vld(t).
  - o_word and o_err_flag are registered and valid only while o_vld=1.
  - o_err_flag is 0 when o_vld=0.
- Words with i_vld=0 advance no counter and no LFSR.
- Reset values:
  - o_vld=0, o_word=0, o_err_flag=0, o_err_cnt=0.
  - State IDLE, cnt=0, pcnt=0, burst_left=0, LFSR=all ones.
- A reset asserted mid-burst ends injection in the same cycle. Output is zero on the following cycle.
- i_enable rising and i_vld in the same cycle: that word is index 0 and is evaluated in WAIT_FIRST (corrupted if first_err=0).

## Configuration
- Macro: CHAN_ERR_INJ_RANDOM_EN.
- Defined: mode 2 is active.
  - A 23-bit LFSR (x^23+x^18+1, seed 0x7FFFFF) advances once per valid word while enabled.
  - The word is corrupted when LFSR[RATE_W-1:0] < err_rate. first_err and burst_len are ignored.
- Undefined: no LFSR logic is built and mode 2 behaves exactly as mode 0.

## Test plan
- Disabled, 100 words of 2'b10 with i_vld every cycle → o_word=2'b10 on all words, o_err_flag never set, o_err_cnt=0, o_vld equals i_vld delayed by 1 cycle.
- Mode 0, first_err=4, err_rate=30, mask=2'b11, all-zero input → corrupted indices 4, 34, 64, …, each with o_word=2'b11; o_err_cnt=4 after 100 words.
- Mode 1, first_err=0, err_rate=10, burst_len=3, mask=2'b01, input valid 1 in 4 cycles → corrupted valid indices 0-2, 10-12, 20-22; o_err_cnt=9 after 30 valid words.
- Mode 1, burst_len=8, err_rate=5 → bursts truncate; valid indices 0-4 and onward are all corrupted continuously.
- Mode 0, WORD_W=4, mask=4'b0001, rot_en=1, err_rate=1 → applied masks cycle 0001, 0010, 0100, 1000, 0001.
- i_enable dropped mid-burst, then reset mid-burst → no corruption from the next word; o_err_cnt holds, then reads 0 after reset.
- Re-enable → corruption restarts at first_err.
